// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and data-memory signal bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misalign;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr_pt;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_wr_en, mem_addr_pt, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_wr_en, mem_addr_pt, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RISC-V load/store controller with sub-word read-modify-write
module lsu_mem_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_ctrl_if.slave  bus
);
  localparam int WIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WR, RESP} state_t;

  state_t           state_q;
  logic [WIDTH+1:0] addr_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merge_q;
  logic [31:0]      rdata_q;
  logic             valid_q;
  logic             mis_q;

  logic             illegal;
  logic             misalign;
  logic             fault;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;
  logic             unused_addr;

  assign unused_addr = ^bus.req_addr[31:WIDTH+2];

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (bus.req_we)
      illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    if (bus.req_funct3[1:0] == 2'b01)
      misalign = bus.req_addr[0];
    else if (bus.req_funct3[1:0] == 2'b10)
      misalign = (bus.req_addr[1:0] != 2'b00);
    fault = illegal || misalign;
  end

  // Lane extraction and insertion both work from the latched address and mem's async read.
  always_comb begin
    byte_lane  = 8'h00;
    half_lane  = bus.mem_rd_data[15:0];
    load_data  = bus.mem_rd_data;
    merge_data = bus.mem_rd_data;
    case (addr_q[1:0])
      2'b00:   byte_lane = bus.mem_rd_data[7:0];
      2'b01:   byte_lane = bus.mem_rd_data[15:8];
      2'b10:   byte_lane = bus.mem_rd_data[23:16];
      default: byte_lane = bus.mem_rd_data[31:24];
    endcase
    if (addr_q[1])
      half_lane = bus.mem_rd_data[31:16];
    case (f3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'h0, byte_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = bus.mem_rd_data;
    endcase
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merge_data[7:0]   = wdata_q[7:0];
        2'b01:   merge_data[15:8]  = wdata_q[7:0];
        2'b10:   merge_data[23:16] = wdata_q[7:0];
        default: merge_data[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_data[31:16] = wdata_q[15:0];
    end else begin
      merge_data[15:0]  = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr[WIDTH+1:0];
            f3_q    <= bus.req_funct3;
            wdata_q <= bus.req_wdata;
            if (fault) begin
              rdata_q <= '0;
              mis_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= RESP;
            end else if (!bus.req_we) begin
              state_q <= LOAD;
            end else if (bus.req_funct3[1:0] == 2'b10) begin
              merge_q <= bus.req_wdata;
              state_q <= WR;
            end else begin
              state_q <= MERGE;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          mis_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        MERGE: begin
          merge_q <= merge_data;
          state_q <= WR;
        end
        WR: begin
          rdata_q <= '0;
          mis_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates the write combinationally so a reset landing on WR never commits.
  assign bus.mem_wr_en     = (state_q == WR) && rst_n;
  assign bus.mem_addr_pt   = addr_q[WIDTH+1:2];
  assign bus.mem_wr_data   = merge_q;
  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = valid_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_misalign = mis_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - vector table, random model comparison and reset-during-write for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_pulses = 0;

  logic [31:0] mem [256];
  logic [7:0]  ref_b [1024];

  lsu_mem_ctrl_if #(.AW(8)) bus ();

  lsu_mem_ctrl #(.DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd_data = mem[bus.mem_addr_pt];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr_pt] <= bus.mem_wr_data;
      wr_pulses <= wr_pulses + 1;
    end
  end

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_mis;
    int          exp_lat;
    int          exp_wr;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: memory wraps at 1 KiB, accesses are little-endian byte groups.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output bit mis,
                       output int lat, output int wr);
    int  a;
    int  size;
    bit  legal;
    logic [31:0] val;
    a    = int'(addr % 1024);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rd = 32'h0;
    wr = 0;
    if (!legal || (a % size) != 0) begin
      mis = 1'b1;
      lat = 1;
    end else if (we) begin
      mis = 1'b0;
      for (int i = 0; i < size; i++) ref_b[a+i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      wr  = 1;
    end else begin
      mis = 1'b0;
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_b[a+i]) << (8*i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      rd  = val;
      lat = 2;
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output bit mis,
                        output int lat, output int wr, output bit busy_bad);
    int w0;
    int wait_c;
    wait_c = 0;
    busy_bad = 1'b0;
    @(negedge clk);
    while (!bus.req_ready && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    w0 = wr_pulses;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
      if (bus.req_ready) busy_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    if (bus.req_ready) busy_bad = 1'b1;
    rd  = bus.resp_rdata;
    mis = bus.resp_misalign;
    @(posedge clk);
    #1;
    if (bus.resp_valid || !bus.req_ready) busy_bad = 1'b1;
    wr = wr_pulses - w0;
  endtask

  initial begin
    logic [31:0] rd, m_rd, addr;
    bit          mis, m_mis, bb, we;
    int          lat, wr, m_lat, m_wr;
    logic [2:0]  f3;

    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, m_rd, addr, wd;
    bit          mis, m_mis, bb, we;
    int          lat, wr, m_lat, m_wr;
    logic [2:0]  f3;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;

    tbl[0]  = '{1'b1, 3'd2, 32'h000, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0,   32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3'd2, 32'h000, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, -1,  32'h0};
    tbl[2]  = '{1'b1, 3'd0, 32'h001, 32'h000000A5, 32'h0,        1'b0, 3, 1, 0,   32'hDEADA5EF};
    tbl[3]  = '{1'b0, 3'd0, 32'h001, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 0, -1,  32'h0};
    tbl[4]  = '{1'b0, 3'd4, 32'h001, 32'h0,        32'h000000A5, 1'b0, 2, 0, -1,  32'h0};
    tbl[5]  = '{1'b0, 3'd0, 32'h003, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, -1,  32'h0};
    tbl[6]  = '{1'b1, 3'd1, 32'h002, 32'h00001234, 32'h0,        1'b0, 3, 1, 0,   32'h1234A5EF};
    tbl[7]  = '{1'b0, 3'd1, 32'h002, 32'h0,        32'h00001234, 1'b0, 2, 0, -1,  32'h0};
    tbl[8]  = '{1'b0, 3'd1, 32'h000, 32'h0,        32'hFFFFA5EF, 1'b0, 2, 0, -1,  32'h0};
    tbl[9]  = '{1'b0, 3'd5, 32'h000, 32'h0,        32'h0000A5EF, 1'b0, 2, 0, -1,  32'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h003, 32'h0,        32'h0,        1'b1, 1, 0, -1,  32'h0};
    tbl[11] = '{1'b1, 3'd1, 32'h005, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 1,   32'h0};
    tbl[12] = '{1'b1, 3'd3, 32'h004, 32'h12345678, 32'h0,        1'b1, 1, 0, 1,   32'h0};
    tbl[13] = '{1'b1, 3'd2, 32'h400, 32'hCAFEBABE, 32'h0,        1'b0, 2, 1, 0,   32'hCAFEBABE};
    tbl[14] = '{1'b0, 3'd2, 32'h000, 32'h0,        32'hCAFEBABE, 1'b0, 2, 0, -1,  32'h0};
    tbl[15] = '{1'b1, 3'd2, 32'h3FC, 32'h11111111, 32'h0,        1'b0, 2, 1, 255, 32'h11111111};
    tbl[16] = '{1'b0, 3'd6, 32'h000, 32'h0,        32'h0,        1'b1, 1, 0, -1,  32'h0};

    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_misalign", 32'(bus.resp_misalign), 32'd0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_mem_addr_pt", 32'(bus.mem_addr_pt), 32'd0);
    check("rst_mem_wr_data", bus.mem_wr_data, 32'h0);

    for (int i = 0; i < 17; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_mis, m_lat, m_wr);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, mis, lat, wr, bb);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_misalign", i), 32'(mis), 32'(tbl[i].exp_mis));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_wr_pulses", i), 32'(wr), 32'(tbl[i].exp_wr));
      check($sformatf("vec%0d_handshake", i), 32'(bb), 32'd0);
      if (tbl[i].mem_idx >= 0)
        check($sformatf("vec%0d_mem", i), mem[tbl[i].mem_idx], tbl[i].exp_mem);
    end

    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
      wd   = $urandom();
      model(we, f3, addr, wd, m_rd, m_mis, m_lat, m_wr);
      do_req(we, f3, addr, wd, rd, mis, lat, wr, bb);
      check($sformatf("rnd%0d_rdata", n), rd, m_rd);
      check($sformatf("rnd%0d_misalign", n), 32'(mis), 32'(m_mis));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat));
      check($sformatf("rnd%0d_wr_pulses", n), 32'(wr), 32'(m_wr));
      check($sformatf("rnd%0d_handshake", n), 32'(bb), 32'd0);
    end

    model(1'b1, 3'd2, 32'h008, 32'h12345678, m_rd, m_mis, m_lat, m_wr);
    do_req(1'b1, 3'd2, 32'h008, 32'h12345678, rd, mis, lat, wr, bb);
    model(1'b0, 3'd2, 32'h008, 32'h0, m_rd, m_mis, m_lat, m_wr);
    do_req(1'b0, 3'd2, 32'h008, 32'h0, rd, mis, lat, wr, bb);
    check("pre_rst_load", rd, 32'h12345678);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h008;
    bus.req_wdata  = 32'h55555555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("wr_cycle_wr_en", 32'(bus.mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("wr_cycle_rst_gates_wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("post_rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_mem2", mem[2], 32'h12345678);

    do_req(1'b0, 3'd2, 32'h008, 32'h0, rd, mis, lat, wr, bb);
    check("post_rst_load", rd, 32'h12345678);
    check("post_rst_load_latency", 32'(lat), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
